// File: rtl/uart_bus_arbiter.sv
// Two-master Wishbone arbiter for the uart slave; grant lands one edge after a request in IDLE, handoff costs no idle cycle.
// Non-owner stalls (ack/err/dat held 0); a slave that never acks is cut off with a one-cycle error after TIMEOUT wait cycles.
`ifndef DAT_WIDTH
`define DAT_WIDTH 64
`endif

module uart_bus_arbiter #(
  parameter int DAT_WIDTH = `DAT_WIDTH,
  parameter int ADR_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [ADR_WIDTH-1:0] m0_adr_i,
  input  logic [DAT_WIDTH-1:0] m0_dat_i,
  output logic [DAT_WIDTH-1:0] m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [ADR_WIDTH-1:0] m1_adr_i,
  input  logic [DAT_WIDTH-1:0] m1_dat_i,
  output logic [DAT_WIDTH-1:0] m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [ADR_WIDTH-1:0] s_adr_o,
  output logic [DAT_WIDTH-1:0] s_dat_o,
  input  logic [DAT_WIDTH-1:0] s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  output logic [1:0]           grant_o
);

  // One-hot encoding so the state register doubles as the registered grant.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  // The error must show in wait cycle TIMEOUT+1, so fire on the edge where wcnt would reach TIMEOUT.
  localparam logic [7:0] TLIM = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       tflag, tflag_nxt;
  logic       own_cyc, own_stb, waiting;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      wcnt  <= '0;
      tflag <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      wcnt  <= wcnt_nxt;
      tflag <= tflag_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    wcnt_nxt  = wcnt;
    tflag_nxt = 1'b0;
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    case (state)
      IDLE: begin
        // With both requesting, last == 1 means master 1 was served most recently.
        if (m0_cyc_i && (!m1_cyc_i || last)) begin
          state_nxt = GNT0;
          last_nxt  = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
          last_nxt  = 1'b1;
        end
      end
      GNT0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        if (!m0_cyc_i) begin
          if (m1_cyc_i) begin
            state_nxt = GNT1;
            last_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GNT1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        if (!m1_cyc_i) begin
          if (m0_cyc_i) begin
            state_nxt = GNT0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The forced-error cycle itself is not a wait cycle, so the count restarts cleanly after it.
    waiting = own_cyc && own_stb && !s_ack_i && !s_err_i && !tflag;
    if ((TIMEOUT == 0) || (state_nxt != state) || !waiting) begin
      wcnt_nxt = '0;
    end else if (wcnt == TLIM) begin
      wcnt_nxt  = '0;
      tflag_nxt = 1'b1;
    end else begin
      wcnt_nxt = wcnt + 8'd1;
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    // Outputs are gated by reset so they drop without waiting for the state register.
    if (rst_i) begin
      case (state)
        GNT0: begin
          s_cyc_o  = m0_cyc_i;
          s_stb_o  = m0_stb_i & ~tflag;
          s_we_o   = m0_we_i;
          s_adr_o  = m0_adr_i;
          s_dat_o  = m0_dat_i;
          m0_ack_o = s_ack_i;
          m0_err_o = s_err_i | tflag;
          m0_dat_o = s_dat_i;
        end
        GNT1: begin
          s_cyc_o  = m1_cyc_i;
          s_stb_o  = m1_stb_i & ~tflag;
          s_we_o   = m1_we_i;
          s_adr_o  = m1_adr_i;
          s_dat_o  = m1_dat_i;
          m1_ack_o = s_ack_i;
          m1_err_o = s_err_i | tflag;
          m1_dat_o = s_dat_i;
        end
        default: ;
      endcase
    end
  end

  assign grant_o = rst_i ? state : 2'b00;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Bench for uart_bus_arbiter: directed scenarios plus random traffic, all checked against a cycle-level model.
module tb_uart_bus_arbiter;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int TO = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_wdat[2];
  logic [DW-1:0] s_rdat;
  logic          s_ack, s_err;

  logic [DW-1:0] d_dat[2];
  logic          d_ack[2], d_err[2];
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic [1:0]    grant;

  logic [DW-1:0] nt_dat[2];
  logic          nt_ack[2], nt_err[2];
  logic          nt_scyc, nt_sstb, nt_swe;
  logic [AW-1:0] nt_sadr;
  logic [DW-1:0] nt_sdat;
  logic [1:0]    nt_grant;

  uart_bus_arbiter #(.DAT_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_adr_i(m_adr[0]),
    .m0_dat_i(m_wdat[0]), .m0_dat_o(d_dat[0]), .m0_ack_o(d_ack[0]), .m0_err_o(d_err[0]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_adr_i(m_adr[1]),
    .m1_dat_i(m_wdat[1]), .m1_dat_o(d_dat[1]), .m1_ack_o(d_ack[1]), .m1_err_o(d_err[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant)
  );

  uart_bus_arbiter #(.DAT_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT(0)) dut_nt (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_adr_i(m_adr[0]),
    .m0_dat_i(m_wdat[0]), .m0_dat_o(nt_dat[0]), .m0_ack_o(nt_ack[0]), .m0_err_o(nt_err[0]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_adr_i(m_adr[1]),
    .m1_dat_i(m_wdat[1]), .m1_dat_o(nt_dat[1]), .m1_ack_o(nt_ack[1]), .m1_err_o(nt_err[1]),
    .s_cyc_o(nt_scyc), .s_stb_o(nt_sstb), .s_we_o(nt_swe), .s_adr_o(nt_sadr), .s_dat_o(nt_sdat),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(nt_grant)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: who owns the bus, who was served last, length of the current stall run.
  int owner  = -1;
  int last_m = 1;
  int waits  = 0;
  bit tf     = 1'b0;

  logic [1:0]    obs_grant;
  logic          obs_sstb;
  logic [DW-1:0] obs_sdat;
  logic          obs_mack[2], obs_merr[2], obs_nterr[2];
  bit            acked[2];

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
      m_adr[k] = '0;   m_wdat[k] = '0;
    end
    s_rdat = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  // Called at posedge+1 after inputs are set; checks at the negedge and advances the model one cycle.
  task automatic step();
    int o, nxt;
    bit stall;
    logic [1:0] e_grant;
    @(negedge clk_i);
    o = owner;
    e_grant = (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
    check("grant", grant, e_grant);
    check("s_cyc", s_cyc, (o >= 0) ? m_cyc[o] : 1'b0);
    check("s_stb", s_stb, (o >= 0) ? (m_stb[o] & ~tf) : 1'b0);
    check("s_we",  s_we,  (o >= 0) ? m_we[o] : 1'b0);
    check("s_adr", s_adr, (o >= 0) ? m_adr[o] : '0);
    check("s_dat", s_wdat, (o >= 0) ? m_wdat[o] : '0);
    check("nt_grant", nt_grant, e_grant);
    for (int k = 0; k < 2; k++) begin
      check("m_ack", d_ack[k], (o == k) ? s_ack : 1'b0);
      check("m_err", d_err[k], (o == k) ? (s_err | tf) : 1'b0);
      check("m_dat", d_dat[k], (o == k) ? s_rdat : '0);
      check("nt_err", nt_err[k], (o == k) ? s_err : 1'b0);
      obs_mack[k]  = d_ack[k];
      obs_merr[k]  = d_err[k];
      obs_nterr[k] = nt_err[k];
      acked[k]     = (o == k) && m_cyc[k] && m_stb[k] && s_ack;
    end
    obs_grant = grant;
    obs_sstb  = s_stb;
    obs_sdat  = s_wdat;

    nxt = o;
    if (o < 0) begin
      if (m_cyc[0] && m_cyc[1]) nxt = 1 - last_m;
      else if (m_cyc[0])        nxt = 0;
      else if (m_cyc[1])        nxt = 1;
    end else if (!m_cyc[o]) begin
      nxt = m_cyc[1-o] ? 1 - o : -1;
    end
    stall = (o >= 0) && m_cyc[o] && m_stb[o] && !s_ack && !s_err && !tf;
    tf = 1'b0;
    if (nxt != o || !stall) waits = 0;
    else begin
      waits++;
      if (waits == TO) begin
        tf = 1'b1;
        waits = 0;
      end
    end
    if (nxt >= 0 && nxt != o) last_m = nxt;
    owner = nxt;
    @(posedge clk_i);
    #1;
  endtask

  // Asserts reset between edges, checks outputs drop at once, holds across one edge, releases at posedge+2.
  task automatic async_reset();
    #3;
    rst_i = 1'b0;
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_scyc", s_cyc, 1'b0);
    check("rst_sstb", s_stb, 1'b0);
    check("rst_swe", s_we, 1'b0);
    check("rst_sadr", s_adr, '0);
    check("rst_sdat", s_wdat, '0);
    for (int k = 0; k < 2; k++) begin
      check("rst_mack", d_ack[k], 1'b0);
      check("rst_merr", d_err[k], 1'b0);
      check("rst_mdat", d_dat[k], '0);
    end
    owner = -1; last_m = 1; waits = 0; tf = 1'b0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
  endtask

  int rem[2];
  bit pause[2];
  int gseq[$];
  logic [1:0] prev_g;
  int cnt0;

  initial begin
    idle_inputs();
    async_reset();

    // Single write from master 0.
    m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_adr[0] = 32'h10; m_wdat[0] = 64'h41;
    s_ack = 1; s_rdat = 64'hDEAD_BEEF_0000_1234;
    step(); check("t1_idle", obs_grant, 2'b00);
    step(); check("t1_grant", obs_grant, 2'b01);
    check("t1_dat", obs_sdat[7:0], 8'h41);
    check("t1_ack0", obs_mack[0], 1'b1);
    check("t1_ack1", obs_mack[1], 1'b0);
    s_ack = 0;
    step(); check("t1_ack0_lo", obs_mack[0], 1'b0);
    idle_inputs(); step(); step();

    // Simultaneous request from reset, handoff, and a blocked re-request.
    async_reset();
    m_cyc[0] = 1; m_stb[0] = 1; m_cyc[1] = 1; m_stb[1] = 1;
    step(); step(); check("ho_first", obs_grant, 2'b01);
    m_cyc[0] = 0; m_stb[0] = 0;
    step(); check("ho_hold", obs_grant, 2'b01);
    step(); check("ho_swap", obs_grant, 2'b10);
    m_cyc[0] = 1; m_stb[0] = 1;
    for (int i = 0; i < 3; i++) begin
      step(); check("ho_block", obs_grant, 2'b10);
    end
    m_cyc[1] = 0; m_stb[1] = 0;
    step(); check("ho_rel", obs_grant, 2'b10);
    step(); check("ho_back", obs_grant, 2'b01);
    idle_inputs(); step(); step();

    // Contention: 10 back-to-back single transfers each.
    async_reset();
    rem[0] = 10; rem[1] = 10; pause[0] = 0; pause[1] = 0; prev_g = 2'b00;
    s_ack = 1;
    for (int n = 0; n < 150 && (rem[0] > 0 || rem[1] > 0); n++) begin
      for (int k = 0; k < 2; k++) begin
        m_cyc[k] = (rem[k] > 0) && !pause[k];
        m_stb[k] = m_cyc[k];
        m_we[k]  = (k == 1);
        m_adr[k] = $urandom;
        m_wdat[k] = {$urandom, $urandom};
      end
      s_rdat = {$urandom, $urandom};
      step();
      if (obs_grant != prev_g && obs_grant != 2'b00) gseq.push_back(obs_grant == 2'b10 ? 1 : 0);
      prev_g = obs_grant;
      for (int k = 0; k < 2; k++) begin
        if (acked[k]) begin
          rem[k]--;
          pause[k] = 1;
        end else pause[k] = 0;
      end
    end
    check("alt_done", rem[0] + rem[1], 0);
    check("alt_cnt", gseq.size(), 20);
    cnt0 = 0;
    foreach (gseq[i]) begin
      check("alt_seq", gseq[i], i % 2);
      if (gseq[i] == 0) cnt0++;
    end
    check("alt_m0", cnt0, 10);
    idle_inputs(); step(); step();

    // Slave never acks: error in the 5th wait cycle and again 5 waits later.
    async_reset();
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h4;
    for (int i = 0; i <= 11; i++) begin
      step();
      check("to_err", obs_merr[0], (i == 5 || i == 10));
      if (i >= 1) check("to_stb", obs_sstb, !(i == 5 || i == 10));
      check("to_nt_err", obs_nterr[0], 1'b0);
    end
    idle_inputs(); step();

    // Reset pulsed mid-transfer, then a simultaneous request goes to master 0.
    m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1; m_wdat[1] = 64'h55AA; s_rdat = 64'h1234_5678;
    s_ack = 1;
    step(); step(); check("mr_owner", obs_grant, 2'b10);
    async_reset();
    m_cyc[0] = 1; m_stb[0] = 1;
    step(); step(); check("mr_regrant", obs_grant, 2'b01);
    idle_inputs(); step();

    // Slave error goes to the owner only and restarts the stall count.
    async_reset();
    m_cyc[0] = 1; m_stb[0] = 1; m_cyc[1] = 1; m_stb[1] = 1;
    step(); step(); step();
    s_err = 1;
    step();
    check("se_own", obs_merr[0], 1'b1);
    check("se_other", obs_merr[1], 1'b0);
    s_err = 0;
    for (int i = 0; i < 4; i++) begin
      step(); check("se_wclr", obs_merr[0], 1'b0);
    end
    step(); check("se_to", obs_merr[0], 1'b1);
    idle_inputs(); step();

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      if (n == 250) async_reset();
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(4) == 0) m_cyc[k] = ~m_cyc[k];
        m_stb[k]  = m_cyc[k] && ($urandom_range(3) != 0);
        m_we[k]   = $urandom_range(1);
        m_adr[k]  = $urandom;
        m_wdat[k] = {$urandom, $urandom};
      end
      s_ack  = ($urandom_range(2) == 0);
      s_err  = ($urandom_range(15) == 0);
      s_rdat = {$urandom, $urandom};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_bus_arbiter.md
# uart_bus_arbiter

Two-master Wishbone arbiter that shares the single `uart` slave port between the CPU core (master 0) and the boot/debug loader (master 1). It grants whole bus cycles, alternates fairly under contention, and terminates with an error any transfer the slave fails to acknowledge within a bounded time. It sits between the two masters' UART address-decode outputs and the `uart` slave ports.

## Interface
- `DAT_WIDTH`, default `` `DAT_WIDTH `` (64): data bus width.
- `ADR_WIDTH`, default 32: address bus width.
- `TIMEOUT`, default 255: maximum wait cycles before a forced error; 0 disables the timeout.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous assert, active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 cycle, strobe and write enable.
- `m0_adr_i`  in  ADR_WIDTH  master 0 address.
- `m0_dat_i`  in  DAT_WIDTH  master 0 write data.
- `m0_dat_o`  out  DAT_WIDTH  master 0 read data.
- `m0_ack_o`, `m0_err_o`  out  1 each  master 0 acknowledge and error.
- `m1_*`: same set as `m0_*`, for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to the slave.
- `s_adr_o`  out  ADR_WIDTH  to the slave.
- `s_dat_o`  out  DAT_WIDTH  write data to the slave.
- `s_dat_i`  in  DAT_WIDTH  read data from the slave.
- `s_ack_i`, `s_err_i`  in  1 each  slave acknowledge and error.
- `grant_o`  out  2  registered one-hot grant; `00` when idle.

## Operation
- Registered state is `IDLE`, `GNT0` or `GNT1`, plus a last-served pointer `last` (1 bit), a wait counter `wcnt` (8 bits) and a timeout flag `tflag`.
- In `IDLE`:
  - Exactly one `mN_cyc_i` high: go to `GNTN`.
  - Both high: grant the master that is not `last`.
  - On any grant, set `last` to the granted index.
- In `GNTN`, while `mN_cyc_i` is high: stay in `GNTN`.
- In `GNTN`, when `mN_cyc_i` goes low:
  - Other master's `cyc_i` high: hand off directly to the other grant.
  - Otherwise: go to `IDLE`.
- Routing is combinational from the grant state.
  - `s_cyc_o = mN_cyc_i`.
  - `s_stb_o = mN_stb_i & ~tflag`.
  - `s_we_o`, `s_adr_o` and `s_dat_o` come from master N.
  - In `IDLE`, all slave outputs are 0.
- Responses to the owner:
  - `mN_ack_o = s_ack_i`.
  - `mN_err_o = s_err_i | tflag`.
  - `mN_dat_o = s_dat_i`.
- The master without the grant sees `ack_o = 0`, `err_o = 0` and `dat_o = 0`, and stalls.
- Timeout (only when `TIMEOUT != 0`):
  - `wcnt` increments on each cycle the owner's `stb_i` is high while `s_ack_i` and `s_err_i` are both low.
  - `wcnt` clears on ack, err, owner `stb_i` low, or any change of grant.
  - When `wcnt == TIMEOUT`, set `tflag` for exactly one cycle and clear `wcnt`.
  - `tflag` clears on the next edge.
- Any combination of inputs not listed above holds the current state.

## Timing
- Reset value of every output: 0.
- Reset (`rst_i` low) forces the block to `IDLE`, with `last = 1`, `wcnt = 0` and `tflag = 0`. It takes effect immediately, without a clock edge, including mid-transfer.
- While `rst_i` is low, all outputs are 0 combinationally: `grant_o = 00` and all slave and master outputs 0.
- Arbitration latency: a request seen in `IDLE` at edge k drives `s_cyc_o`/`s_stb_o` from just after edge k. The first slave ack can therefore come in cycle k+1.
- Handoff: the owner drops `cyc_i` before edge k, the other master is granted at edge k, with no idle cycle in between.
- Acks pass through in zero cycles. Both the slave's combinational ack (`stb`-qualified) and multi-beat cycles under one `cyc_i` are supported.
- Timeout error: `mN_err_o` is high in the cycle after `wcnt` reaches `TIMEOUT`, i.e. the TIMEOUT+1'th wait cycle. In that same cycle `s_stb_o` is forced to 0.
- If the owner drops `cyc_i` in the same cycle `tflag` is set, the error is discarded and the grant releases normally.
- Simultaneous requests arriving on the same edge are resolved by `last` alone. There is no fixed priority.

## Test plan
- Reset, then `m0_cyc`/`m0_stb` high with `we = 1`, `dat = 0x41` → `grant_o = 01` after one edge, `s_dat_o[7:0] = 0x41`, `m0_ack_o` follows `s_ack_i`, `m1_ack_o = 0`.
- Both masters request from reset → master 0 is granted first. Master 0 drops `cyc` → `grant_o` becomes `10` on the next edge with no idle cycle. Master 0 requests again while master 1 holds → it is not granted until master 1 releases.
- Contention over 10 back-to-back single transfers from each master → grants alternate `01, 10, 01, …`, with exactly 10 per master.
- Slave holds `s_ack_i = 0` with `TIMEOUT = 4` → `m0_err_o` pulses for exactly one cycle in the 5th wait cycle, `s_stb_o = 0` in that cycle, and the counter restarts afterwards. With `TIMEOUT = 0`, no error ever occurs.
- `rst_i` is pulsed low mid-transfer (asynchronously, between edges) → all outputs are 0 immediately. After release, the next simultaneous request grants master 0.
- A slave error (`s_err_i = 1`) → it passes to the owner's `err_o` only. The non-owner's `err_o` stays 0 and `wcnt` clears.
